// File: rtl/sample_loader_pkg.sv
// Shared definitions for the sample loader: FSM states, frame layout constants
// and a saturating counter helper.
package sample_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PIXELS  = 3'd1,
      ST_LABEL   = 3'd2,
      ST_START   = 3'd3,
      ST_WAIT_FP = 3'd4,
      ST_WAIT_BP = 3'd5
   } state_e;

   localparam int HDR_MODE_BIT = 0;
   localparam int HDR_LEN      = 1;
   localparam int LABEL_LEN    = 1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sample_loader_if.sv
// Byte-stream handshake carrying frames into the loader.
interface sample_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sample_loader_argmax_unit.sv
// Combinational argmax over unsigned class scores; ties go to the lowest index.
module argmax_unit #(
   parameter int CLASSES = 10
) (
   input  logic [CLASSES-1:0][7:0] scores,
   output logic [3:0]              idx
);

   logic [7:0] best;

   // Strict greater-than keeps the earliest maximum on ties
   always_comb begin
      best = scores[0];
      idx  = 4'd0;
      for (int i = 1; i < CLASSES; i++) begin
         if (scores[i] > best) begin
            best = scores[i];
            idx  = 4'(i);
         end else begin
            idx  = idx;
         end
      end
   end

endmodule

// File: rtl/sample_loader.sv
// Frame loader: assembles header/pixels/label from a byte stream, launches the
// network, scores its prediction and keeps saturating accuracy counters.
module sample_loader
   import sample_loader_pkg::*;
#(
   parameter int IMG_SIZE = 256,
   parameter int CLASSES  = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   sample_loader_if.slave           in_if,
   output logic [IMG_SIZE-1:0][7:0] img,
   output logic [7:0]               label_val,
   output logic                     train_buff,
   output logic                     test_buff,
   output logic                     start_forprop,
   output logic                     start_backprop,
   input  logic                     forprop_done,
   input  logic                     backprop_done,
   input  logic [CLASSES-1:0][7:0]  result,
   output logic [3:0]               pred,
   output logic                     pred_valid,
   output logic                     pred_correct,
   output logic [15:0]              sample_count,
   output logic [15:0]              correct_count
);

   localparam int CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_SIZE - 1);

   state_e                   state_q, state_d;
   logic                     mode_q, mode_d;
   logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic [IMG_SIZE-1:0][7:0] img_q, img_d;
   logic [7:0]               label_val_q, label_val_d;
   logic                     in_ready_q, in_ready_d;
   logic                     train_buff_q, train_buff_d;
   logic                     test_buff_q, test_buff_d;
   logic                     start_fp_q, start_fp_d;
   logic                     start_bp_q, start_bp_d;
   logic [3:0]               pred_q, pred_d;
   logic                     pred_valid_q, pred_valid_d;
   logic                     pred_correct_q, pred_correct_d;
   logic [15:0]              sample_count_q, sample_count_d;
   logic [15:0]              correct_count_q, correct_count_d;
   logic [3:0]               argmax_idx;
   logic                     xfer;
   logic                     hit;

   argmax_unit #(.CLASSES(CLASSES)) u_argmax (
      .scores (result),
      .idx    (argmax_idx)
   );

   assign xfer = in_if.in_valid && in_ready_q;
   assign hit  = (label_val_q < 8'(CLASSES)) && (argmax_idx == label_val_q[3:0]);

   // Next-state and next-output logic; outputs are derived from the next state
   // so every registered output lines up with the state it belongs to.
   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      pix_cnt_d       = pix_cnt_q;
      img_d           = img_q;
      label_val_d     = label_val_q;
      pred_d          = pred_q;
      pred_valid_d    = 1'b0;
      pred_correct_d  = pred_correct_q;
      sample_count_d  = sample_count_q;
      correct_count_d = correct_count_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               mode_d    = in_if.in_data[HDR_MODE_BIT];
               pix_cnt_d = '0;
               state_d   = ST_PIXELS;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_PIXELS: begin
            if (xfer) begin
               img_d[pix_cnt_q] = in_if.in_data;
               if (pix_cnt_q == LAST_PIX) begin
                  state_d = ST_LABEL;
               end else begin
                  pix_cnt_d = pix_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_PIXELS;
            end
         end
         ST_LABEL: begin
            if (xfer) begin
               label_val_d = in_if.in_data;
               state_d     = ST_START;
            end else begin
               state_d     = ST_LABEL;
            end
         end
         ST_START: begin
            state_d = ST_WAIT_FP;
         end
         ST_WAIT_FP: begin
            if (forprop_done) begin
               pred_d          = argmax_idx;
               pred_valid_d    = 1'b1;
               pred_correct_d  = hit;
               sample_count_d  = sat_inc(sample_count_q);
               correct_count_d = hit ? sat_inc(correct_count_q) : correct_count_q;
               state_d         = mode_q ? ST_WAIT_BP : ST_IDLE;
            end else begin
               state_d         = ST_WAIT_FP;
            end
         end
         ST_WAIT_BP: begin
            if (backprop_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_BP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_PIXELS) || (state_d == ST_LABEL);
      start_fp_d   = (state_d == ST_START) && !mode_d;
      start_bp_d   = (state_d == ST_START) && mode_d;
      train_buff_d = (state_d != ST_IDLE) && mode_d;
      test_buff_d  = (state_d != ST_IDLE) && !mode_d;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         mode_q          <= 1'b0;
         pix_cnt_q       <= '0;
         img_q           <= '0;
         label_val_q     <= 8'd0;
         in_ready_q      <= 1'b1;
         train_buff_q    <= 1'b0;
         test_buff_q     <= 1'b0;
         start_fp_q      <= 1'b0;
         start_bp_q      <= 1'b0;
         pred_q          <= 4'd0;
         pred_valid_q    <= 1'b0;
         pred_correct_q  <= 1'b0;
         sample_count_q  <= 16'd0;
         correct_count_q <= 16'd0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         pix_cnt_q       <= pix_cnt_d;
         img_q           <= img_d;
         label_val_q     <= label_val_d;
         in_ready_q      <= in_ready_d;
         train_buff_q    <= train_buff_d;
         test_buff_q     <= test_buff_d;
         start_fp_q      <= start_fp_d;
         start_bp_q      <= start_bp_d;
         pred_q          <= pred_d;
         pred_valid_q    <= pred_valid_d;
         pred_correct_q  <= pred_correct_d;
         sample_count_q  <= sample_count_d;
         correct_count_q <= correct_count_d;
      end
   end

   assign in_if.in_ready = in_ready_q;
   assign img            = img_q;
   assign label_val      = label_val_q;
   assign train_buff     = train_buff_q;
   assign test_buff      = test_buff_q;
   assign start_forprop  = start_fp_q;
   assign start_backprop = start_bp_q;
   assign pred           = pred_q;
   assign pred_valid     = pred_valid_q;
   assign pred_correct   = pred_correct_q;
   assign sample_count   = sample_count_q;
   assign correct_count  = correct_count_q;

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader: test/train frames, ties, stalls, resets
// and counter saturation, all against hand-computed expectations.
module tb_sample_loader;
   import sample_loader_pkg::*;

   localparam int IMG_SIZE = 256;
   localparam int CLASSES  = 10;

   logic                     clk;
   logic                     reset;
   logic [IMG_SIZE-1:0][7:0] img;
   logic [7:0]               label_val;
   logic                     train_buff, test_buff;
   logic                     start_forprop, start_backprop;
   logic                     forprop_done, backprop_done;
   logic [CLASSES-1:0][7:0]  result;
   logic [3:0]               pred;
   logic                     pred_valid, pred_correct;
   logic [15:0]              sample_count, correct_count;

   int n_tests;
   int n_fail;
   int fp_pulses;
   int bp_pulses;
   int both_pulses;
   int fp_before;
   int bp_before;

   sample_loader_if bus ();

   sample_loader #(.IMG_SIZE(IMG_SIZE), .CLASSES(CLASSES)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_if          (bus.slave),
      .img            (img),
      .label_val      (label_val),
      .train_buff     (train_buff),
      .test_buff      (test_buff),
      .start_forprop  (start_forprop),
      .start_backprop (start_backprop),
      .forprop_done   (forprop_done),
      .backprop_done  (backprop_done),
      .result         (result),
      .pred           (pred),
      .pred_valid     (pred_valid),
      .pred_correct   (pred_correct),
      .sample_count   (sample_count),
      .correct_count  (correct_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor sampled on the falling edge
   always @(negedge clk) begin
      if (start_forprop) fp_pulses++;
      if (start_backprop) bp_pulses++;
      if (start_forprop && start_backprop) both_pulses++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) check_eq("send_timeout", 32'(n), 32'd0);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] lbl, input bit gap, input int npix);
      send_byte(hdr);
      for (int k = 0; k < npix; k++) begin
         if (gap) step();
         send_byte(8'(k & 255));
      end
      if (npix == IMG_SIZE) begin
         if (gap) step();
         send_byte(lbl);
      end
   endtask

   task automatic pulse_fp();
      forprop_done = 1'b1;
      step();
      forprop_done = 1'b0;
   endtask

   task automatic pulse_bp();
      backprop_done = 1'b1;
      step();
      backprop_done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic set_peak(input int idx, input logic [7:0] v);
      for (int i = 0; i < CLASSES; i++) result[i] = 8'h01;
      result[idx] = v;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
      check_eq({tag, "_buffs"}, {30'd0, train_buff, test_buff}, 32'd0);
      check_eq({tag, "_starts"}, {30'd0, start_forprop, start_backprop}, 32'd0);
      check_eq({tag, "_pred"}, {26'd0, pred, pred_valid, pred_correct}, 32'd0);
      check_eq({tag, "_label"}, 32'(label_val), 32'd0);
      check_eq({tag, "_counts"}, {sample_count, correct_count}, 32'd0);
      check_eq({tag, "_img"}, {img[0], img[50], img[100], img[255]}, 32'd0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      fp_pulses = 0; bp_pulses = 0; both_pulses = 0;
      reset = 1'b1;
      bus.in_data = 8'd0; bus.in_valid = 1'b0;
      forprop_done = 1'b0; backprop_done = 1'b0;
      set_peak(3, 8'h20);
      step(); step();
      reset = 1'b0;
      check_reset_state("rst");

      // Stray completion pulses in IDLE are ignored
      pulse_fp();
      pulse_bp();
      check_eq("idle_done_ignored", {16'(pred_valid), sample_count}, 32'd0);

      // Frame 1: test mode, label 3, peak at class 3
      fp_before = fp_pulses; bp_before = bp_pulses;
      send_frame(8'h00, 8'd3, 1'b0, IMG_SIZE);
      check_eq("f1_start", {30'd0, start_forprop, start_backprop}, 32'b10);
      check_eq("f1_ready_start", 32'(bus.in_ready), 32'd0);
      check_eq("f1_buffs", {30'd0, train_buff, test_buff}, 32'b01);
      check_eq("f1_img", {img[0], img[1], img[100], img[255]}, 32'h00016_4FF >> 0 | 32'h0001_64FF);
      check_eq("f1_label", 32'(label_val), 32'd3);
      step();
      pulse_fp();
      check_eq("f1_pred", {26'd0, pred, pred_valid, pred_correct}, {26'd0, 4'd3, 1'b1, 1'b1});
      check_eq("f1_counts", {sample_count, correct_count}, {16'd1, 16'd1});
      check_eq("f1_idle", {29'd0, bus.in_ready, train_buff, test_buff}, 32'b100);
      step();
      check_eq("f1_pv_pulse", 32'(pred_valid), 32'd0);
      check_eq("f1_npulse", {16'(fp_pulses - fp_before), 16'(bp_pulses - bp_before)}, {16'd1, 16'd0});

      // Frame 2: train mode, label 5; early backprop_done ignored in WAIT_FP
      set_peak(5, 8'h80);
      fp_before = fp_pulses; bp_before = bp_pulses;
      send_frame(8'h01, 8'd5, 1'b0, IMG_SIZE);
      check_eq("f2_start", {30'd0, start_forprop, start_backprop}, 32'b01);
      check_eq("f2_buffs", {30'd0, train_buff, test_buff}, 32'b10);
      step();
      pulse_bp();
      step();
      check_eq("f2_bp_ignored", {30'd0, bus.in_ready, pred_valid}, 32'd0);
      pulse_fp();
      check_eq("f2_pred", {26'd0, pred, pred_valid, pred_correct}, {26'd0, 4'd5, 1'b1, 1'b1});
      step(); step(); step();
      check_eq("f2_wait_bp", {30'd0, bus.in_ready, train_buff}, 32'b01);
      pulse_bp();
      check_eq("f2_idle", {29'd0, bus.in_ready, train_buff, test_buff}, 32'b100);
      check_eq("f2_counts", {sample_count, correct_count}, {16'd2, 16'd2});
      check_eq("f2_npulse", {16'(fp_pulses - fp_before), 16'(bp_pulses - bp_before)}, {16'd0, 16'd1});

      // Frame 3: header upper bits set (still test), in_valid gaps, tie 2/7, label 12
      result = '0;
      for (int i = 0; i < CLASSES; i++) result[i] = 8'h05;
      result[2] = 8'h1F;
      result[7] = 8'h1F;
      send_frame(8'hFE, 8'd12, 1'b1, IMG_SIZE);
      check_eq("f3_buffs", {30'd0, train_buff, test_buff}, 32'b01);
      check_eq("f3_img", {img[2], img[77], img[128], img[254]}, 32'h024D_80FE);
      check_eq("f3_label", 32'(label_val), 32'd12);
      step();
      bus.in_data = 8'hAA;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("f3_offer_blocked", 32'(bus.in_ready), 32'd0);
      check_eq("f3_img_stable", {img[0], img[255], label_val}, {8'h00, 8'hFF, 8'd12});
      bus.in_valid = 1'b0;
      pulse_fp();
      check_eq("f3_pred", {26'd0, pred, pred_valid, pred_correct}, {26'd0, 4'd2, 1'b1, 1'b0});
      check_eq("f3_counts", {sample_count, correct_count}, {16'd3, 16'd2});
      check_eq("f3_idle", 32'(bus.in_ready), 32'd1);

      // Reset mid-frame at pixel 100
      send_frame(8'h01, 8'd0, 1'b0, 100);
      check_eq("f4_mid_buffs", {30'd0, train_buff, test_buff}, 32'b10);
      do_reset();
      check_reset_state("rst_mid");

      // Full frame after reset
      set_peak(3, 8'h20);
      send_frame(8'h00, 8'd3, 1'b0, IMG_SIZE);
      step();
      pulse_fp();
      check_eq("f5_pred", {26'd0, pred, pred_valid, pred_correct}, {26'd0, 4'd3, 1'b1, 1'b1});
      check_eq("f5_counts", {sample_count, correct_count}, {16'd1, 16'd1});

      // Reset while waiting for backprop
      send_frame(8'h01, 8'd3, 1'b0, IMG_SIZE);
      step();
      pulse_fp();
      step();
      check_eq("f6_in_wait_bp", {30'd0, bus.in_ready, train_buff}, 32'b01);
      do_reset();
      check_reset_state("rst_bp");

      // Counter saturation: preload both counters one below the ceiling
      step();
      force dut.sample_count_q = 16'hFFFE;
      force dut.correct_count_q = 16'hFFFE;
      #1;
      release dut.sample_count_q;
      release dut.correct_count_q;
      step();
      check_eq("sat_preload", {sample_count, correct_count}, 32'hFFFE_FFFE);
      for (int f = 0; f < 2; f++) begin
         send_frame(8'h00, 8'd3, 1'b0, IMG_SIZE);
         step();
         pulse_fp();
         check_eq("sat_counts", {sample_count, correct_count}, 32'hFFFF_FFFF);
      end

      check_eq("never_both_starts", 32'(both_pulses), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
